// File: rtl/nmos_clockgen_mp.sv
// Multi-phase NMOS chip clock generator: a 2*PHASES-state Johnson-style phase
// counter stepped by master ticks, with halt-at-phase stretch and sync realign.
module nmos_clockgen_mp #(
    parameter int PHASES     = 4,
    parameter int STOP_PHASE = 0,
    parameter int SYNC_PHASE = 0
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          C28M,
    input  logic                          HALT,
    input  logic                          SYNC,
    output logic [PHASES-1:0]             PH,
    output logic [PHASES-1:0]             PH_N,
    output logic [PHASES-1:0]             PH_R,
    output logic [PHASES-1:0]             PH_F,
    output logic [PHASES/2-1:0]           DBL,
    output logic [$clog2(2*PHASES)-1:0]   PHASE_IDX,
    output logic                          STALLED
);
    localparam int NST = 2 * PHASES;
    localparam int IW  = $clog2(NST);
    localparam logic [IW-1:0] STOP_IDX = IW'(STOP_PHASE);
    localparam logic [IW-1:0] SYNC_IDX = IW'(SYNC_PHASE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NST - 1);

    logic [IW-1:0]        idx_q, idx_d;
    logic                 stalled_q, stalled_d;
    logic [PHASES-1:0]    ph_q, ph_d;
    logic [PHASES-1:0]    ph_n_q, ph_n_d;
    logic [PHASES-1:0]    ph_r_q, ph_r_d;
    logic [PHASES-1:0]    ph_f_q, ph_f_d;
    logic [PHASES/2-1:0]  dbl_q, dbl_d;
    logic                 adv;

    // Phase k is high for state indices in (k, k+PHASES].
    function automatic logic [PHASES-1:0] jdec(input logic [IW-1:0] i);
        logic [PHASES-1:0] j;
        int ii;
        ii = int'(i);
        for (int k = 0; k < PHASES; k++)
            j[k] = (k < ii) && (ii <= k + PHASES);
        return j;
    endfunction

    always_comb begin
        idx_d     = idx_q;
        stalled_d = stalled_q;
        adv       = 1'b0;
        if (SYNC) begin
            idx_d     = SYNC_IDX;
            stalled_d = 1'b0;
        end else if (C28M) begin
            if (HALT && idx_q == STOP_IDX) begin
                stalled_d = 1'b1;
            end else begin
                idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                stalled_d = 1'b0;
                adv       = 1'b1;
            end
        end
        ph_d   = jdec(idx_d);
        ph_n_d = ~ph_d;
        // ph_q always holds the decode of idx_q, so it doubles as the old level.
        ph_r_d = adv ? (ph_d & ~ph_q) : '0;
        ph_f_d = adv ? (ph_q & ~ph_d) : '0;
        dbl_d  = '0;
        for (int k = 0; k < PHASES / 2; k++)
            dbl_d[k] = ph_d[k] ^ ph_d[k + PHASES / 2];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx_q     <= '0;
            stalled_q <= 1'b0;
            ph_q      <= '0;
            ph_n_q    <= '1;
            ph_r_q    <= '0;
            ph_f_q    <= '0;
            dbl_q     <= '0;
        end else begin
            idx_q     <= idx_d;
            stalled_q <= stalled_d;
            ph_q      <= ph_d;
            ph_n_q    <= ph_n_d;
            ph_r_q    <= ph_r_d;
            ph_f_q    <= ph_f_d;
            dbl_q     <= dbl_d;
        end
    end

    assign PH        = ph_q;
    assign PH_N      = ph_n_q;
    assign PH_R      = ph_r_q;
    assign PH_F      = ph_f_q;
    assign DBL       = dbl_q;
    assign PHASE_IDX = idx_q;
    assign STALLED   = stalled_q;
endmodule

// File: tb/tb_nmos_clockgen_mp.sv
// Bench for nmos_clockgen_mp: two configurations driven in lockstep and
// compared every cycle against an index-level reference model.
module tb_nmos_clockgen_mp;
    logic CLK = 1'b0;
    logic RESET, C28M, HALT, SYNC;

    logic [3:0] ph_a, ph_n_a, ph_r_a, ph_f_a;
    logic [1:0] dbl_a;
    logic [2:0] idx_a;
    logic       st_a;

    logic [5:0] ph_b, ph_n_b, ph_r_b, ph_f_b;
    logic [2:0] dbl_b;
    logic [3:0] idx_b;
    logic       st_b;

    nmos_clockgen_mp #(.PHASES(4), .STOP_PHASE(3), .SYNC_PHASE(5)) dut_a (
        .CLK(CLK), .RESET(RESET), .C28M(C28M), .HALT(HALT), .SYNC(SYNC),
        .PH(ph_a), .PH_N(ph_n_a), .PH_R(ph_r_a), .PH_F(ph_f_a), .DBL(dbl_a),
        .PHASE_IDX(idx_a), .STALLED(st_a));

    nmos_clockgen_mp #(.PHASES(6), .STOP_PHASE(8), .SYNC_PHASE(2)) dut_b (
        .CLK(CLK), .RESET(RESET), .C28M(C28M), .HALT(HALT), .SYNC(SYNC),
        .PH(ph_b), .PH_N(ph_n_b), .PH_R(ph_r_b), .PH_F(ph_f_b), .DBL(dbl_b),
        .PHASE_IDX(idx_b), .STALLED(st_b));

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per configuration, the state index and expected outputs.
    int          m_p    [2] = '{4, 6};
    int          m_stop [2] = '{3, 8};
    int          m_sync [2] = '{5, 2};
    int          m_idx  [2];
    bit          m_st   [2];
    logic [11:0] m_ph   [2];
    logic [11:0] m_r    [2];
    logic [11:0] m_f    [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] phases_at(input int p, input int i);
        logic [11:0] v = '0;
        for (int k = 0; k < p; k++) v[k] = (k < i) && (i <= k + p);
        return v;
    endfunction

    function automatic logic [11:0] dbl_of(input int p, input logic [11:0] v);
        logic [11:0] d = '0;
        for (int k = 0; k < p / 2; k++) d[k] = v[k] ^ v[k + p / 2];
        return d;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_st[d] = 0; m_ph[d] = '0; m_r[d] = '0; m_f[d] = '0;
        end
    endtask

    task automatic model_step(input bit c, input bit h, input bit s);
        for (int d = 0; d < 2; d++) begin
            logic [11:0] old_v, new_v;
            old_v = m_ph[d];
            m_r[d] = '0;
            m_f[d] = '0;
            if (s) begin
                m_idx[d] = m_sync[d];
                m_st[d]  = 0;
            end else if (c && h && m_idx[d] == m_stop[d]) begin
                m_st[d] = 1;
            end else if (c) begin
                m_idx[d] = (m_idx[d] + 1) % (2 * m_p[d]);
                m_st[d]  = 0;
                new_v    = phases_at(m_p[d], m_idx[d]);
                m_r[d]   = new_v & ~old_v;
                m_f[d]   = old_v & ~new_v;
            end
            m_ph[d] = phases_at(m_p[d], m_idx[d]);
        end
    endtask

    task automatic check_all();
        logic [11:0] ma, mb;
        ma = 12'h00F;
        mb = 12'h03F;
        chk("A.idx", 32'(idx_a), 32'(m_idx[0]));
        chk("A.ph", 32'(ph_a), 32'(m_ph[0]));
        chk("A.ph_n", 32'(ph_n_a), 32'(~m_ph[0] & ma));
        chk("A.ph_r", 32'(ph_r_a), 32'(m_r[0]));
        chk("A.ph_f", 32'(ph_f_a), 32'(m_f[0]));
        chk("A.dbl", 32'(dbl_a), 32'(dbl_of(4, m_ph[0])));
        chk("A.stalled", 32'(st_a), 32'(m_st[0]));
        chk("B.idx", 32'(idx_b), 32'(m_idx[1]));
        chk("B.ph", 32'(ph_b), 32'(m_ph[1]));
        chk("B.ph_n", 32'(ph_n_b), 32'(~m_ph[1] & mb));
        chk("B.ph_r", 32'(ph_r_b), 32'(m_r[1]));
        chk("B.ph_f", 32'(ph_f_b), 32'(m_f[1]));
        chk("B.dbl", 32'(dbl_b), 32'(dbl_of(6, m_ph[1])));
        chk("B.stalled", 32'(st_b), 32'(m_st[1]));
    endtask

    task automatic cyc(input bit c, input bit h, input bit s);
        C28M = c; HALT = h; SYNC = s;
        @(posedge CLK);
        model_step(c, h, s);
        @(negedge CLK);
        check_all();
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 40 && int'(idx_a) != target; n++) cyc(1, 0, 0);
        chk("reach_idx", 32'(idx_a), 32'(target));
    endtask

    int          rise_cnt [4];
    int          fall_cnt [4];
    int          ticks;
    logic [3:0]  exp_ph  [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [1:0]  exp_dbl [8] = '{2'b01, 2'b11, 2'b10, 2'b00,
                                 2'b01, 2'b11, 2'b10, 2'b00};
    int          b_high;

    initial begin
        RESET = 1'b1; C28M = 1'b0; HALT = 1'b0; SYNC = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check_all();
        RESET = 1'b0;

        // Tick every second CLK from reset: walk one full period of config A.
        b_high = 0;
        for (int t = 0; t < 16; t++) begin
            cyc(t % 2 == 0, 0, 0);
            if (t % 2 == 0) begin
                chk("A.seq_idx", 32'(idx_a), 32'((t / 2 + 1) % 8));
                chk("A.seq_ph", 32'(ph_a), 32'(exp_ph[t / 2]));
                chk("A.seq_dbl", 32'(dbl_a), 32'(exp_dbl[t / 2]));
                if (ph_b[0]) b_high++;
            end
        end
        // Phase 0 of the 6-phase config is high for ticks 1..6 of the first 8.
        chk("B.ph0_high_ticks", 32'(b_high), 32'd6);

        // Strobe census over 64 irregularly spaced ticks (8 full A periods).
        for (int k = 0; k < 4; k++) begin rise_cnt[k] = 0; fall_cnt[k] = 0; end
        ticks = 0;
        for (int n = 0; n < 1000 && ticks < 64; n++) begin
            bit c;
            c = 1'($urandom_range(0, 1));
            cyc(c, 0, 0);
            if (c) ticks++;
            for (int k = 0; k < 4; k++) begin
                rise_cnt[k] += int'(ph_r_a[k]);
                fall_cnt[k] += int'(ph_f_a[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk("A.rise_count", 32'(rise_cnt[k]), 32'd8);
            chk("A.fall_count", 32'(fall_cnt[k]), 32'd8);
        end

        // Halt at STOP_PHASE=3, then release.
        for (int n = 0; n < 12; n++) cyc(1, 1, 0);
        chk("A.halt_idx", 32'(idx_a), 32'd3);
        chk("A.halt_ph", 32'(ph_a), 32'b0111);
        chk("A.halt_stalled", 32'(st_a), 32'd1);
        chk("A.halt_no_strobe", 32'({ph_r_a, ph_f_a}), 32'd0);
        cyc(1, 0, 0);
        chk("A.release_idx", 32'(idx_a), 32'd4);
        chk("A.release_ph_r3", 32'(ph_r_a[3]), 32'd1);
        chk("A.release_stalled", 32'(st_a), 32'd0);

        // SYNC at index 2 together with a tick.
        run_to(2);
        cyc(1, 0, 1);
        chk("A.sync_idx", 32'(idx_a), 32'd5);
        chk("A.sync_ph", 32'(ph_a), 32'b1110);
        chk("A.sync_strobes", 32'({ph_r_a, ph_f_a}), 32'd0);
        cyc(1, 0, 0);
        chk("A.post_sync_idx", 32'(idx_a), 32'd6);
        chk("A.post_sync_ph_f1", 32'(ph_f_a[1]), 32'd1);

        // SYNC beats HALT while stalled at STOP_PHASE.
        run_to(3);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        chk("A.pre_sync_stalled", 32'(st_a), 32'd1);
        cyc(1, 1, 1);
        chk("A.sync_halt_idx", 32'(idx_a), 32'd5);
        chk("A.sync_halt_stalled", 32'(st_a), 32'd0);

        // Asynchronous reset between clock edges at index 6.
        run_to(6);
        #2 RESET = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RESET = 1'b0;
        check_all();
        for (int n = 0; n < 8; n++) begin
            cyc(1, 0, 0);
            chk("A.b2b_idx", 32'(idx_a), 32'((n + 1) % 8));
        end

        // Randomized traffic with mixed halts and occasional syncs.
        for (int n = 0; n < 600; n++)
            cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 40) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/nmos_clockgen_mp.md
Name: nmos_clockgen_mp

Overview:
Parametrised multi-phase clock generator. Successor to the fixed 4-phase 3.5 MHz / 7 MHz chip clock generator.
- Steps a 2*PHASES-state phase counter once per master tick (C28M high for one CLK).
- Emits PHASES overlapping phase clocks, each offset by one tick, with inverted copies and one-CLK rising/falling edge strobes.
- Emits PHASES/2 double-rate XOR clocks.
- Adds a halt-at-phase (bus stretch) mode and a synchronous phase realign, neither of which the fixed generator has.
- Sits at the top of every NMOS chip model and feeds the per-chip phase enables.

Parameters:
PHASES, 4, number of phase clocks. Even, >= 2. Output period = 2*PHASES ticks.
STOP_PHASE, 0, state index at which HALT freezes the counter. Range 0..2*PHASES-1.
SYNC_PHASE, 0, state index loaded by SYNC. Range 0..2*PHASES-1.

Ports:
CLK  in  1  simulation main clock; everything is clocked on its rising edge
RESET  in  1  asynchronous, active-high reset
C28M  in  1  master tick enable; one tick = one CLK with C28M=1
HALT  in  1  request to freeze at STOP_PHASE
SYNC  in  1  single-CLK pulse: force the state index to SYNC_PHASE
PH  out  PHASES  phase clocks
PH_N  out  PHASES  inverted phase clocks
PH_R  out  PHASES  rising-edge strobes, one CLK wide
PH_F  out  PHASES  falling-edge strobes, one CLK wide
DBL  out  PHASES/2  double-rate clocks
PHASE_IDX  out  clog2(2*PHASES)  current state index, registered
STALLED  out  1  high while a tick is being withheld by HALT

Behaviour:
- State: index i, 0..2*PHASES-1. Decoded Johnson bits: J[k] = 1 iff k < i <= k+PHASES (k = 0..PHASES-1).
- Asynchronous reset while RESET=1:
  - i=0; PH=0; PH_N=all ones; PH_R=0; PH_F=0; DBL=0; PHASE_IDX=0; STALLED=0.
  - Reset mid-period discards the state. After RESET deasserts, the first tick moves i to 1.
- Priority each CLK:
  1. SYNC=1: i <= SYNC_PHASE, regardless of C28M or HALT. PH_R/PH_F are forced to 0 in that output cycle. PH/DBL jump directly to the decoded values for SYNC_PHASE.
  2. Else C28M=1, HALT=1 and i==STOP_PHASE: i holds; STALLED <= 1.
  3. Else C28M=1: i <= (i==2*PHASES-1) ? 0 : i+1; STALLED <= 0.
  4. Else (no tick): i holds; STALLED holds its value.
- HALT is sampled only on ticks. HALT=1 at any other index has no effect until the index reaches STOP_PHASE.
- HALT release: the first tick with HALT=0 advances the counter and clears STALLED.
- Registered outputs, one CLK latency from the CLK that updates i:
  - PH[k] = J[k] of the new i.
  - PH_N[k] = ~PH[k].
  - DBL[k] = J[k] XOR J[k+PHASES/2].
  - PHASE_IDX = new i.
- Strobes:
  - PH_R[k] = 1 for exactly the CLK in which PH[k] first reads 1 after an advancing tick.
  - PH_F[k] is the same for the first CLK in which PH[k] reads 0.
  - A stalled tick produces no strobes.
- Each phase is high for PHASES ticks and low for PHASES ticks. Phase k+1 lags phase k by one tick.
- DBL has period PHASES ticks and 50% duty.
- Back-to-back ticks (C28M held high) are legal: one advance per CLK.
- Wrap from 2*PHASES-1 to 0 produces PH_F[PHASES-1] in the same CLK as the wrap.

Test Plan:
- PHASES=4, C28M=1 every 2nd CLK, after reset:
  - PHASE_IDX sequence 1,2,...,7,0.
  - PH sequence 0001,0011,0111,1111,1110,1100,1000,0000.
  - DBL sequence 01,11,10,00 repeating, i.e. 2 ticks per level.
- Count strobes over 64 ticks: exactly 8 PH_R[k] and 8 PH_F[k] pulses per k. Each pulse is coincident with the first CLK of the new PH[k] level. No pulse without a preceding tick.
- STOP_PHASE=3, HALT=1 held:
  - Counter freezes at PHASE_IDX=3 with PH=0111.
  - STALLED=1 after the first withheld tick; no strobes.
  - Drop HALT: the next tick gives PHASE_IDX=4, PH_R[3]=1 and STALLED=0.
- SYNC_PHASE=5: pulse SYNC at PHASE_IDX=2 together with C28M=1. Next output shows PHASE_IDX=5, PH=1110, all strobes 0. The next tick gives PHASE_IDX=6 and PH_F[1]=1.
- SYNC and HALT both high at STOP_PHASE: SYNC wins (PHASE_IDX=SYNC_PHASE) and STALLED is not set.
- Assert RESET asynchronously mid-cycle at PHASE_IDX=6: outputs go to reset values with no CLK edge. After release, C28M held high for 8 CLKs walks i through 1..7,0 with one advance per CLK.
- Repeat the first scenario with PHASES=6: 12-state period, DBL width 3, each phase high for 6 ticks.
